// File: rtl/msdap_out_serializer_pkg.sv
// Shared types and constants for the MSDAP output serializer slice.
package msdap_pkg;

  localparam int MSDAP_WORD_W = 40;
  localparam int MSDAP_CNT_W  = 6;

  typedef logic [MSDAP_WORD_W-1:0] msdap_word_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } msdap_state_t;

endpackage

// File: rtl/msdap_out_serializer_if.sv
// Parallel result handshake plus serial output bundle of the MSDAP output stage.
interface msdap_out_serializer_if
  import msdap_pkg::*;
#(
  parameter int WORD_W = MSDAP_WORD_W
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_dataL;
  logic [WORD_W-1:0] in_dataR;
  logic              OutputL;
  logic              OutputR;
  logic              OutReady;
  logic              busy;

  modport master (
    output in_valid, in_dataL, in_dataR,
    input  in_ready, OutputL, OutputR, OutReady, busy
  );

  modport slave (
    input  in_valid, in_dataL, in_dataR,
    output in_ready, OutputL, OutputR, OutReady, busy
  );
endinterface

// File: rtl/msdap_piso_2ch.sv
// Two-channel parallel-load, shift-right register with bit counter and last-bit flag.
module msdap_piso_2ch
  import msdap_pkg::*;
#(
  parameter int WORD_W = MSDAP_WORD_W,
  parameter int CNT_W  = MSDAP_CNT_W
) (
  input  logic              Sclk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_l,
  input  logic [WORD_W-1:0] load_r,
  output logic              bit_l,
  output logic              bit_r,
  output logic              last
);
  logic [1:0][WORD_W-1:0] load_data;
  logic [1:0][WORD_W-1:0] sh_reg;
  logic [CNT_W-1:0]       cnt_reg;

  assign load_data[0] = load_l;
  assign load_data[1] = load_r;

  // The serial bit is the LSB of each shifter, so the outputs are register-driven.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      always_ff @(posedge Sclk) begin
        if (Reset || clr) begin
          sh_reg[gi] <= '0;
        end else if (load) begin
          sh_reg[gi] <= load_data[gi];
        end else if (shift) begin
          sh_reg[gi] <= {1'b0, sh_reg[gi][WORD_W-1:1]};
        end
      end
    end
  endgenerate

  always_ff @(posedge Sclk) begin
    if (Reset || clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (shift) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bit_l = sh_reg[0][0];
  assign bit_r = sh_reg[1][0];
  assign last  = (cnt_reg == CNT_W'(WORD_W - 1));
endmodule

// File: rtl/msdap_out_serializer.sv
// MSDAP output stage: one pending pair plus a two-channel LSB-first shifter.
// Optional upstream overrun counter enabled by MSDAP_OUT_DROP_CNT_EN.
module msdap_out_serializer
  import msdap_pkg::*;
#(
  parameter int WORD_W = MSDAP_WORD_W,
  parameter int CNT_W  = MSDAP_CNT_W
) (
  input  logic                  Sclk,
  input  logic                  Reset,
  input  logic                  Clear,
  msdap_out_serializer_if.slave bus
`ifdef MSDAP_OUT_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);
  msdap_state_t      state_reg, state_next;
  logic              pend_vld_reg, pend_vld_next;
  logic [WORD_W-1:0] pend_l_reg, pend_l_next;
  logic [WORD_W-1:0] pend_r_reg, pend_r_next;
  logic [WORD_W-1:0] load_l, load_r;
  logic              flush, in_ready, accept;
  logic              piso_load, piso_shift, piso_clr, piso_last;

  assign flush    = Reset | Clear;
  assign in_ready = ~pend_vld_reg & ~flush;
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      pend_vld_reg <= 1'b0;
      pend_l_reg   <= '0;
      pend_r_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pend_vld_reg <= pend_vld_next;
      pend_l_reg   <= pend_l_next;
      pend_r_reg   <= pend_r_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pend_vld_next = pend_vld_reg;
    pend_l_next   = pend_l_reg;
    pend_r_next   = pend_r_reg;
    load_l        = bus.in_dataL;
    load_r        = bus.in_dataR;
    piso_load     = 1'b0;
    piso_shift    = 1'b0;
    piso_clr      = 1'b0;
    if (Clear) begin
      state_next    = ST_IDLE;
      pend_vld_next = 1'b0;
      piso_clr      = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            piso_load  = 1'b1;
            state_next = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!piso_last) begin
            piso_shift = 1'b1;
            if (accept) begin
              pend_l_next   = bus.in_dataL;
              pend_r_next   = bus.in_dataR;
              pend_vld_next = 1'b1;
            end
          end else if (pend_vld_reg) begin
            // Final-bit edge: hand the pending pair straight to the shifter, no gap.
            load_l        = pend_l_reg;
            load_r        = pend_r_reg;
            piso_load     = 1'b1;
            pend_vld_next = 1'b0;
          end else if (accept) begin
            piso_load = 1'b1;
          end else begin
            piso_clr   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  msdap_piso_2ch #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_piso (
    .Sclk   (Sclk),
    .Reset  (Reset),
    .clr    (piso_clr),
    .load   (piso_load),
    .shift  (piso_shift),
    .load_l (load_l),
    .load_r (load_r),
    .bit_l  (bus.OutputL),
    .bit_r  (bus.OutputR),
    .last   (piso_last)
  );

  assign bus.in_ready = in_ready;
  assign bus.OutReady = (state_reg == ST_SHIFT);
  assign bus.busy     = (state_reg == ST_SHIFT) | pend_vld_reg;

`ifdef MSDAP_OUT_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge Sclk) begin
    if (flush) begin
      drop_cnt_reg <= '0;
    end else if (bus.in_valid && !in_ready && drop_cnt_reg != 8'hFF) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif
endmodule

// File: tb/tb_msdap_out_serializer.sv
// Directed self-checking bench for msdap_out_serializer (default and MSDAP_OUT_DROP_CNT_EN builds).
module tb_msdap_out_serializer;
  import msdap_pkg::*;

  logic Sclk = 1'b0;
  logic Reset;
  logic Clear;
  int   n_cmp = 0;
  int   n_err = 0;

  msdap_out_serializer_if #(.WORD_W(MSDAP_WORD_W)) bus ();

`ifdef MSDAP_OUT_DROP_CNT_EN
  logic [7:0] drop_cnt;
  msdap_out_serializer dut (
    .Sclk     (Sclk),
    .Reset    (Reset),
    .Clear    (Clear),
    .bus      (bus.slave),
    .drop_cnt (drop_cnt)
  );
`else
  msdap_out_serializer dut (
    .Sclk  (Sclk),
    .Reset (Reset),
    .Clear (Clear),
    .bus   (bus.slave)
  );
`endif

  always #5 Sclk = ~Sclk;

  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " OutReady"}, 64'(bus.OutReady), 64'd0);
    chk({tag, " OutputL"},  64'(bus.OutputL),  64'd0);
    chk({tag, " OutputR"},  64'(bus.OutputR),  64'd0);
    chk({tag, " busy"},     64'(bus.busy),     64'd0);
  endtask

  // Presents one pair in IDLE and checks all 40 serial bits and the return to idle.
  task automatic send_word(input string tag, input msdap_word_t l, input msdap_word_t r);
    bus.in_valid = 1'b1;
    bus.in_dataL = l;
    bus.in_dataR = r;
    chk({tag, " ready"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < MSDAP_WORD_W; i++) begin
      chk($sformatf("%s OutReady b%0d", tag, i), 64'(bus.OutReady), 64'd1);
      chk($sformatf("%s L b%0d", tag, i), 64'(bus.OutputL), 64'(l[i]));
      chk($sformatf("%s R b%0d", tag, i), 64'(bus.OutputR), 64'(r[i]));
      tick();
    end
    chk_idle({tag, " end"});
  endtask

  msdap_word_t wl [3];
  msdap_word_t wr [3];

  initial begin
    msdap_word_t xl, xr, yl, yr, el, er;
    int          pres;
    logic        acc;

    // Reset, Clear and in_valid together: nothing may be accepted.
    Reset        = 1'b1;
    Clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_dataL = 40'hFF_FFFF_FFFF;
    bus.in_dataR = 40'hFF_FFFF_FFFF;
    repeat (3) tick();
    chk_idle("rst");
    chk("rst in_ready", 64'(bus.in_ready), 64'd0);
`ifdef MSDAP_OUT_DROP_CNT_EN
    chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    Reset        = 1'b0;
    Clear        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("post-rst in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk_idle("post-rst");

    // Single word with isolated set bits at both ends.
    send_word("single", 40'h00_0000_0001, 40'h80_0000_0000);

    // Three back-to-back pairs, offered whenever in_ready is high.
    wl[0] = 40'hA5_A5A5_A5A5; wr[0] = 40'h5A_5A5A_5A5A;
    wl[1] = 40'h12_3456_789A; wr[1] = 40'hFE_DCBA_9876;
    wl[2] = 40'hFF_FFFF_FFFF; wr[2] = 40'h00_0000_0000;
    pres         = 0;
    bus.in_valid = 1'b1;
    bus.in_dataL = wl[0];
    bus.in_dataR = wr[0];
    for (int k = 0; k <= 120; k++) begin
      acc = bus.in_valid & bus.in_ready;
      tick();
      if (acc) pres++;
      bus.in_valid = (pres < 3);
      if (pres < 3) begin
        bus.in_dataL = wl[pres];
        bus.in_dataR = wr[pres];
      end
      if (k < 120) begin
        el = wl[k / 40];
        er = wr[k / 40];
        chk($sformatf("b2b OutReady c%0d", k), 64'(bus.OutReady), 64'd1);
        chk($sformatf("b2b L c%0d", k), 64'(bus.OutputL), 64'(el[k % 40]));
        chk($sformatf("b2b R c%0d", k), 64'(bus.OutputR), 64'(er[k % 40]));
      end else begin
        chk_idle("b2b end");
      end
      // Pending is full after edges 1..39 and 41..79.
      chk($sformatf("b2b in_ready c%0d", k), 64'(bus.in_ready),
          64'(!((k >= 1 && k <= 39) || (k >= 41 && k <= 79))));
    end

    // Direct accept on the final bit with the pending register empty.
    xl = 40'h0F_1E2D_3C4B; xr = 40'hB4_C3D2_E1F0;
    yl = 40'h96_6996_6996; yr = 40'h01_8000_0001;
    bus.in_valid = 1'b1;
    bus.in_dataL = xl;
    bus.in_dataR = xr;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k <= 80; k++) begin
      if (k < 80) begin
        el = (k < 40) ? xl : yl;
        er = (k < 40) ? xr : yr;
        chk($sformatf("last OutReady c%0d", k), 64'(bus.OutReady), 64'd1);
        chk($sformatf("last L c%0d", k), 64'(bus.OutputL), 64'(el[k % 40]));
        chk($sformatf("last R c%0d", k), 64'(bus.OutputR), 64'(er[k % 40]));
      end else begin
        chk_idle("last end");
      end
      if (k == 39) begin
        chk("last in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_dataL = yl;
        bus.in_dataR = yr;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end

    // Clear at bit 17 with the pending register full.
    xl = 40'h13_5724_68AC; xr = 40'hEC_A8DB_9753;
    bus.in_valid = 1'b1;
    bus.in_dataL = xl;
    bus.in_dataR = xr;
    tick();
    bus.in_dataL = 40'hAA_AAAA_AAAA;
    bus.in_dataR = 40'h55_5555_5555;
    tick();
    bus.in_valid = 1'b0;
    repeat (16) tick();
    chk("clr bit17 L", 64'(bus.OutputL), 64'(xl[17]));
    chk("clr bit17 R", 64'(bus.OutputR), 64'(xr[17]));
    chk("clr full busy", 64'(bus.busy), 64'd1);
    chk("clr full in_ready", 64'(bus.in_ready), 64'd0);
    Clear = 1'b1;
    tick();
    chk_idle("clr");
    Clear = 1'b0;
    #1;
    chk("clr in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk_idle("clr settled");
    send_word("after-clr", 40'hC3_0F1E_2D3C, 40'h7E_8100_FF01);

`ifdef MSDAP_OUT_DROP_CNT_EN
    // Continuous offering stalls on most cycles; the counter must saturate.
    bus.in_valid = 1'b1;
    bus.in_dataL = 40'h11_1111_1111;
    bus.in_dataR = 40'h22_2222_2222;
    repeat (320) tick();
    chk("drop_cnt sat", 64'(drop_cnt), 64'd255);
    bus.in_valid = 1'b0;
    Clear = 1'b1;
    tick();
    chk("drop_cnt clr", 64'(drop_cnt), 64'd0);
    Clear = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/msdap_out_serializer.md
Name: msdap_out_serializer

Overview:
- Output stage directly downstream of the MSDAP filter datapath.
- Accepts parallel 40-bit left/right filter results through a valid/ready handshake.
- Buffers up to two result pairs: one in the shifter, one pending.
- Shifts each pair out LSB-first on OutputL/OutputR, one bit per Sclk, with OutReady framing the 40-bit word; back-to-back words are sent with no gap.

Parameters:
- WORD_W, 40, bits per output word per channel.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W >= WORD_W.

Ports:
- Sclk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Clear  input  1  synchronous flush, e.g. on filter sleep or restart; drops shifter and pending contents.
- in_valid  input  1  result pair present on in_dataL/in_dataR.
- in_ready  output  1  block can accept a pair this cycle.
- in_dataL  input  WORD_W  left-channel result, two's complement.
- in_dataR  input  WORD_W  right-channel result, two's complement.
- OutputL  output  1  left serial bit.
- OutputR  output  1  right serial bit.
- OutReady  output  1  high while a word's bits are on OutputL/OutputR.
- busy  output  1  shifter or pending register occupied.

Behaviour:
- Reset dominates Clear; Clear dominates all other activity.
- On Reset or Clear: state=IDLE, bit count=0, pend_vld=0, shifters=0, OutputL=OutputR=0, OutReady=0, busy=0. Any word in flight is truncated immediately, with no partial completion.
- Handshake: accept = in_valid & in_ready. in_ready = ~pend_vld & ~Reset & ~Clear, driven by registers only; there is no combinational path from in_valid.
- IDLE, on accept: the data loads the shifters; next edge state=SHIFT, count=0, OutReady=1, OutputL/R = bit 0. Accept-to-first-bit latency is 1 Sclk.
- SHIFT, each edge: count++, shifters shift right, and OutputL/R present bit[count]. Outputs are registered and each bit is held exactly one cycle.
- SHIFT, accept while count<WORD_W-1: data goes to the pending register and pend_vld=1.
- Final bit (count==WORD_W-1), on the next edge:
  - if pend_vld: pending moves to the shifters, pend_vld=0, count=0, OutReady stays 1, and bit 0 of the new word is driven with no gap.
  - else if accept in the same cycle: input goes directly to the shifters, same as above, no gap.
  - else: state=IDLE, OutReady=0, OutputL/R=0.
- OutReady is high for exactly WORD_W×N consecutive cycles for N back-to-back words.
- busy = (state==SHIFT) | pend_vld.
- Full condition: pend_vld=1 while in SHIFT holds in_ready low until the final-bit edge hands pending off.
- Data is passed bit-exact; no sign handling, rounding or truncation.

Optional Feature:
- Macro: MSDAP_OUT_DROP_CNT_EN.
- Defined:
  - adds output drop_cnt[7:0], counting cycles where in_valid=1 and in_ready=0.
  - saturates at 255.
  - cleared by Reset or Clear.
  - observability of upstream overrun.
- Undefined: no port and no counter logic; behaviour otherwise identical.

Decomposition:
- Package msdap_pkg:
  - MSDAP_WORD_W=40.
  - state enum {ST_IDLE, ST_SHIFT}.
  - typedef of the 40-bit result word.
- Sub-module msdap_piso_2ch: the two-channel parallel-load, shift-right register with bit counter and last-bit flag. The top level holds the FSM, pending register and handshake.

Test Plan:
- Single word: in_dataL=40'h00_0000_0001, in_dataR=40'h80_0000_0000, one accept in IDLE -> OutReady high for 40 cycles starting 1 cycle later; OutputL=1 only on bit 0; OutputR=1 only on bit 39; then OutReady=0.
- Back-to-back: three pairs presented whenever in_ready is high (A5A5A5A5A5/5A5A5A5A5A, 123456789A/FEDCBA9876, FFFFFFFFFF/0000000000) -> OutReady high for 120 contiguous cycles, every bit matches LSB-first, in_ready low while pending is full.
- Last-bit direct accept: pend_vld=0, accept asserted exactly at count==39 -> new word bit 0 follows with no gap, no loss.
- Clear mid-word at bit 17 with pending full -> next edge OutReady=0, busy=0, in_ready=1; a following word is output complete and correct.
- Reset with Clear and in_valid all high simultaneously -> all outputs 0, nothing accepted.
- With MSDAP_OUT_DROP_CNT_EN: hold in_valid high through 300 stalled cycles -> drop_cnt saturates at 255; Clear returns it to 0.
